// File: rtl/aes_encipher_iter_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the iterative encipher core:
//   - FSM state type and round counts for AES-128 / AES-256
//   - S-box lookup and Rcon table
//   - GF(2^8) helpers (xtime, MixColumns) and byte-level round transforms
// Byte ordering everywhere: byte 0 of a 128-bit block sits in bits [127:120],
// and the state is column-major (byte index = 4*column + row).
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int NR_128 = 10;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_state_e;

    localparam logic [0:255][7:0] SBOX_TABLE = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[b];
    endfunction

    // Successive powers of x in GF(2^8); index 0 and indices past 10 follow
    // the same sequence so any 4-bit index yields a defined constant.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h8d;
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            4'd11:   rc = 8'h6c;
            4'd12:   rc = 8'hd8;
            4'd13:   rc = 8'hab;
            4'd14:   rc = 8'h4d;
            default: rc = 8'h9a;
        endcase
        return rc;
    endfunction

    // Multiply by x, reducing by the AES polynomial (0x11B).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = sbox(s[127 - 8*i -: 8]);
        end
        return o;
    endfunction

    // Row r of the column-major state rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = mix_column(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_encipher_iter_key_step.sv
// ---------------------------------------------------------------------------
// aes_key_step
// Combinational one-round step of the on-the-fly AES key schedule.
// The key size is selected by KEY_BITS (128 or 256).
//   key_win   in   KEY_BITS  key window held for the current round
//   round_idx in   4         round being executed (1..NR)
//   next_win  out  KEY_BITS  window to hold for the following round
//   round_key out  128       round key for round_idx
//
// AES-128: the window is the previous round key; the round key is derived
//          from it with Rcon(round_idx) and also becomes the next window.
// AES-256: for round r the window is {w[4r-4..4r-1], w[4r..4r+3]}, so the
//          round key is simply the lower half. The step computes the four
//          words for round r+1: odd r produces an even round's key (RotWord,
//          SubWord and Rcon((r+1)/2)), even r produces an odd round's key
//          (SubWord only).
// ---------------------------------------------------------------------------
module aes_key_step
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic [KEY_BITS-1:0] key_win,
    input  logic [3:0]          round_idx,
    output logic [KEY_BITS-1:0] next_win,
    output logic [127:0]        round_key
);

    if (KEY_BITS == 256) begin : g_key_256
        logic [31:0] temp;
        logic [31:0] n0, n1, n2, n3;
        logic [3:0]  rcon_idx;

        always_comb begin
            rcon_idx = (round_idx + 4'd1) >> 1;
            if (round_idx[0]) begin
                temp = sub_word(rot_word(key_win[31:0])) ^ {rcon(rcon_idx), 24'h0};
            end else begin
                temp = sub_word(key_win[31:0]);
            end
            n0 = key_win[255:224] ^ temp;
            n1 = key_win[223:192] ^ n0;
            n2 = key_win[191:160] ^ n1;
            n3 = key_win[159:128] ^ n2;
            round_key = key_win[127:0];
            next_win  = {key_win[127:0], n0, n1, n2, n3};
        end
    end else begin : g_key_128
        logic [31:0] temp;
        logic [31:0] n0, n1, n2, n3;

        always_comb begin
            temp = sub_word(rot_word(key_win[31:0])) ^ {rcon(round_idx), 24'h0};
            n0 = key_win[127:96] ^ temp;
            n1 = key_win[95:64]  ^ n0;
            n2 = key_win[63:32]  ^ n1;
            n3 = key_win[31:0]   ^ n2;
            round_key = {n0, n1, n2, n3};
            next_win  = {n0, n1, n2, n3};
        end
    end

endmodule

// File: rtl/aes_encipher_iter.sv
// ---------------------------------------------------------------------------
// aes_encipher_iter
// Iterative AES encryption core: one round per clock, round keys expanded on
// the fly. Valid/ready handshake on input and output; no block overlap.
//   clk          in   1         rising-edge clock
//   rst_n        in   1         synchronous reset, active-low
//   in_valid     in   1         plain_text/key_text valid
//   in_ready     out  1         core can accept a block (IDLE)
//   plain_text   in   128       block, byte 0 = bits [127:120]
//   key_text     in   KEY_BITS  cipher key, byte 0 = MSB byte
//   out_valid    out  1         cipher_text valid (DONE)
//   out_ready    in   1         downstream accepts cipher_text
//   cipher_text  out  128       result, stable until the output handshake
//   busy         out  1         from accept until the output handshake
// Accept at edge T: rounds run on edges T+1..T+NR, out_valid rises with the
// last round, so one block completes every NR+2 cycles under full flow.
// ---------------------------------------------------------------------------
module aes_encipher_iter
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        plain_text,
    input  logic [KEY_BITS-1:0] key_text,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        cipher_text,
    output logic                busy
);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_encipher_iter: KEY_BITS must be 128 or 256, got %0d", KEY_BITS);
    end

    localparam int         NR         = (KEY_BITS == 256) ? NR_256 : NR_128;
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    aes_state_e          state_q, state_d;
    logic [3:0]          round_ctr_q, round_ctr_d;
    logic [127:0]        data_q, data_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [KEY_BITS-1:0] key_next;
    logic [127:0]        round_key;
    logic [127:0]        sb_sr;
    logic [127:0]        round_out;

    aes_key_step #(
        .KEY_BITS (KEY_BITS)
    ) u_key_step (
        .key_win   (key_q),
        .round_idx (round_ctr_q),
        .next_win  (key_next),
        .round_key (round_key)
    );

    // Single shared round; the final round bypasses MixColumns.
    always_comb begin
        sb_sr     = shift_rows(sub_bytes(data_q));
        round_out = ((round_ctr_q == LAST_ROUND) ? sb_sr : mix_columns(sb_sr)) ^ round_key;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned; a missing default here would infer a latch.
        state_d     = state_q;
        round_ctr_d = round_ctr_q;
        data_d      = data_q;
        key_d       = key_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    data_d      = plain_text ^ key_text[KEY_BITS-1 -: 128];
                    key_d       = key_text;
                    round_ctr_d = 4'd1;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                data_d      = round_out;
                key_d       = key_next;
                round_ctr_d = round_ctr_q + 4'd1;
                if (round_ctr_q == LAST_ROUND) begin
                    round_ctr_d = 4'd0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered views of the next state.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // NOTE: the wide data and key registers are reset along with the control
    // state so an aborted block leaves no partial result or key behind.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            round_ctr_q <= 4'd0;
            data_q      <= '0;
            key_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_ctr_q <= round_ctr_d;
            data_q      <= data_d;
            key_q       <= key_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign cipher_text = data_q;

endmodule

// File: tb/tb_aes_encipher_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_encipher_iter
// Drives an AES-128 and an AES-256 instance of aes_encipher_iter with FIPS-197
// vectors and random blocks. Random results are compared with a byte-array
// AES model whose S-box is derived from GF(2^8) inversion plus the affine map.
// Latency is counted as clock edges from the accept edge up to and including
// the first edge at which out_valid is seen high.
// ---------------------------------------------------------------------------
module tb_aes_encipher_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   in_valid;
    logic [1:0]   in_ready;
    logic [1:0]   out_valid;
    logic [1:0]   out_ready;
    logic [1:0]   busy;
    logic [127:0] plain_text;
    logic [255:0] key_bus;
    logic [127:0] ct128, ct256;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sbox_ref [256];

    always #5 clk = ~clk;

    aes_encipher_iter #(.KEY_BITS(128)) u_dut128 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid[0]),
        .in_ready    (in_ready[0]),
        .plain_text  (plain_text),
        .key_text    (key_bus[127:0]),
        .out_valid   (out_valid[0]),
        .out_ready   (out_ready[0]),
        .cipher_text (ct128),
        .busy        (busy[0])
    );

    aes_encipher_iter #(.KEY_BITS(256)) u_dut256 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid[1]),
        .in_ready    (in_ready[1]),
        .plain_text  (plain_text),
        .key_text    (key_bus),
        .out_valid   (out_valid[1]),
        .out_ready   (out_ready[1]),
        .cipher_text (ct256),
        .busy        (busy[1])
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw_ref(input logic [31:0] w);
        return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
    endfunction

    // nk = 4 uses key[127:0]; nk = 8 uses key[255:0].
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] key, input int nk);
        logic [31:0]  w [60];
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        int           nr;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[nk*32 - 1 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int j = 1; j < i / nk; j++) rc = gf_mul(rc, 8'h02);
                t = subw_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                t = subw_ref(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int j = 0; j < 16; j++) st[j] = pt[127 - 8*j -: 8] ^ w[j/4][31 - 8*(j%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int j = 0; j < 16; j++) st[j] = sbox_ref[st[j]];
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 4; k++) tmp[4*c + k] = st[4*((c + k) % 4) + k];
            st = tmp;
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
                    st[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
                end
            end
            for (int j = 0; j < 16; j++) st[j] = st[j] ^ w[4*r + j/4][31 - 8*(j%4) -: 8];
        end
        for (int j = 0; j < 16; j++) res[127 - 8*j -: 8] = st[j];
        return res;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [127:0] get_ct(input int k);
        return (k == 1) ? ct256 : ct128;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 2'b00;
        out_ready = 2'b00;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Presents a block and returns just after the accept edge.
    task automatic send(input int k, input logic [127:0] pt, input logic [255:0] key);
        int n = 0;
        plain_text  = pt;
        key_bus     = key;
        in_valid[k] = 1'b1;
        while (!in_ready[k] && n < 50) begin
            tick();
            n++;
        end
        check($sformatf("accept_ready_k%0d", k), in_ready[k], 1);
        tick();
        in_valid[k] = 1'b0;
    endtask

    // Returns when out_valid is seen high; the next edge is the output edge.
    task automatic wait_out(input int k, output logic [127:0] ct, output int lat);
        int n = 0;
        while (!out_valid[k] && n < 100) begin
            tick();
            n++;
        end
        check($sformatf("out_valid_timeout_k%0d", k), out_valid[k], 1);
        lat = n + 1;
        ct  = get_ct(k);
    endtask

    task automatic run_vector(input string tag, input int k, input logic [127:0] pt,
                              input logic [255:0] key, input logic [127:0] exp_ct, input int exp_lat);
        logic [127:0] ct;
        int           lat;
        out_ready[k] = 1'b1;
        send(k, pt, key);
        check({tag, "_busy"}, busy[k], 1);
        check({tag, "_in_ready_low"}, in_ready[k], 0);
        wait_out(k, ct, lat);
        check({tag, "_ct"}, ct, exp_ct);
        check({tag, "_latency"}, lat, exp_lat);
        tick();
        check({tag, "_post_out_valid"}, out_valid[k], 0);
        check({tag, "_post_in_ready"}, in_ready[k], 1);
        check({tag, "_post_busy"}, busy[k], 0);
        out_ready[k] = 1'b0;
    endtask

    task automatic back_to_back(input int k);
        logic [127:0] exp_q [$];
        logic [127:0] pt;
        logic [255:0] key;
        logic [127:0] ct_s;
        logic         acc, hs;
        int           sent = 0, got = 0, cyc = 0, last_out = -1;
        int           nr;
        nr  = (k == 1) ? 14 : 10;
        pt  = rand256()[127:0];
        key = rand256();
        plain_text   = pt;
        key_bus      = key;
        in_valid[k]  = 1'b1;
        out_ready[k] = 1'b1;
        while (got < 4 && cyc < 500) begin
            acc  = in_valid[k] && in_ready[k];
            hs   = out_valid[k] && out_ready[k];
            ct_s = get_ct(k);
            tick();
            cyc++;
            if (acc) begin
                exp_q.push_back(aes_ref(pt, key, (k == 1) ? 8 : 4));
                sent++;
                if (sent < 4) begin
                    pt  = rand256()[127:0];
                    key = rand256();
                    plain_text = pt;
                    key_bus    = key;
                end else begin
                    in_valid[k] = 1'b0;
                end
            end
            if (hs) begin
                check($sformatf("b2b_k%0d_pending", k), exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check($sformatf("b2b_k%0d_ct%0d", k, got), ct_s, exp_q.pop_front());
                if (last_out >= 0) check($sformatf("b2b_k%0d_interval%0d", k, got), cyc - last_out, nr + 2);
                last_out = cyc;
                got++;
            end
        end
        check($sformatf("b2b_k%0d_count", k), got, 4);
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] ct, exp_ct, pt;
        logic [255:0] key;
        int           lat;

        plain_text = '0;
        key_bus    = '0;
        build_sbox();
        do_reset();

        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_in_ready_k%0d", k), in_ready[k], 1);
            check($sformatf("reset_out_valid_k%0d", k), out_valid[k], 0);
            check($sformatf("reset_busy_k%0d", k), busy[k], 0);
            check($sformatf("reset_ct_k%0d", k), get_ct(k), 0);
        end

        run_vector("c1", 0, PT_C1, {128'h0, KEY_C1}, CT_C1, 11);
        run_vector("appb", 0, PT_B, {128'h0, KEY_B}, CT_B, 11);
        run_vector("c3", 1, PT_C1, KEY_C3, CT_C3, 15);

        // Backpressure: hold the result while inputs churn.
        pt     = rand256()[127:0];
        key    = rand256();
        exp_ct = aes_ref(pt, key, 4);
        out_ready[0] = 1'b0;
        send(0, pt, key);
        wait_out(0, ct, lat);
        check("bp_ct", ct, exp_ct);
        for (int i = 0; i < 20; i++) begin
            in_valid[0] = i[0];
            plain_text  = rand256()[127:0];
            key_bus     = rand256();
            tick();
            check($sformatf("bp_ct_hold%0d", i), ct128, exp_ct);
            check($sformatf("bp_status%0d", i), {in_ready[0], out_valid[0], busy[0]}, 3'b011);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        check("bp_release_out_valid", out_valid[0], 0);
        check("bp_release_in_ready", in_ready[0], 1);
        tick();
        check("bp_no_second_accept", busy[0], 0);
        out_ready[0] = 1'b0;

        // Reset in the middle of round 5.
        out_ready[0] = 1'b1;
        send(0, PT_C1, {128'h0, KEY_C1});
        repeat (4) tick();
        check("mid_reset_running", busy[0], 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_reset_out_valid", out_valid[0], 0);
        check("mid_reset_in_ready", in_ready[0], 1);
        check("mid_reset_busy", busy[0], 0);
        out_ready[0] = 1'b0;
        run_vector("c1_after_reset", 0, PT_C1, {128'h0, KEY_C1}, CT_C1, 11);

        back_to_back(0);
        back_to_back(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
